// File: rtl/tm_pkg.sv
// Shared types and widths for the tape loader slice: loader state encoding
// plus the nibble and display bus widths.
package tm_pkg;
  localparam int NIBBLE_W  = 4;
  localparam int DISPLAY_W = 11;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    GAP,
    DONE,
    WAIT
  } tmState_e;
endpackage

// File: rtl/tm_tape_loader_if.sv
// Bus bundle between a host and the tape loader.
// slave is the loader side; master is the host/machine side.
interface tm_tape_loader_if;
  import tm_pkg::*;

  logic                 wr_en;
  logic [NIBBLE_W-1:0]  wr_data;
  logic                 start;
  logic                 full;
  logic                 busy;
  logic [NIBBLE_W-1:0]  input_data;
  logic                 Next;
  logic                 Done;
  logic                 compute_done;
  logic [DISPLAY_W-1:0] display_in;
  logic [DISPLAY_W-1:0] result;
  logic                 result_valid;
  logic                 timeout;

  modport slave (
    input  wr_en, wr_data, start, compute_done, display_in,
    output full, busy, input_data, Next, Done, result, result_valid, timeout
  );

  modport master (
    output wr_en, wr_data, start, compute_done, display_in,
    input  full, busy, input_data, Next, Done, result, result_valid, timeout
  );
endinterface

// File: rtl/Synchronizer.sv
// Two-flop synchronizer for bringing asynchronous signals into the clock domain.
module Synchronizer #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);
  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;
endmodule

// File: rtl/tm_nibble_fifo.sv
// DEPTH x 4 nibble FIFO. Full and empty are derived from an explicit count;
// a push while full is dropped, and a pop while empty is ignored.
module tm_nibble_fifo
  import tm_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [NIBBLE_W-1:0]      i_pushData,
  input  logic                     i_pop,
  output logic [NIBBLE_W-1:0]      o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [NIBBLE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]       r_wrPtr;
  logic [AW-1:0]       r_rdPtr;
  logic [AW:0]         r_count;
  logic                w_doPush;
  logic                w_doPop;

  assign o_full   = (r_count == (AW+1)'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign o_head   = r_mem[r_rdPtr];
  assign o_count  = r_count;

  always_ff @(posedge clock) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_pushData;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/tm_tape_loader.sv
// Streams queued tape nibbles to the machine with Next/Done strobes held HOLD
// cycles each, then waits for the machine's completion and captures its display.
module tm_tape_loader
  import tm_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int HOLD    = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic             clock,
  input  logic             reset,
  tm_tape_loader_if.slave  bus
);
  localparam int HCW = $clog2(HOLD);
  localparam int TCW = $clog2(TIMEOUT);
  localparam int CW  = $clog2(DEPTH) + 1;

  tmState_e             r_state;
  logic [HCW-1:0]       r_holdCnt;
  logic [TCW-1:0]       r_waitCnt;
  logic [NIBBLE_W-1:0]  r_data;
  logic                 r_busy;
  logic                 r_next;
  logic                 r_done;
  logic [DISPLAY_W-1:0] r_result;
  logic                 r_resultValid;
  logic                 r_timeout;

  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_haveData;
  logic                 w_lastHold;
  logic                 w_cdSync;
  logic [NIBBLE_W-1:0]  w_head;
  logic [CW-1:0]        w_count;
  logic [DISPLAY_W-1:0] w_dispSync;

  tm_nibble_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .i_push     (bus.wr_en),
    .i_pushData (bus.wr_data),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count)
  );

  Synchronizer #(.WIDTH(1)) u_syncDone (
    .clock   (clock),
    .reset   (reset),
    .i_async (bus.compute_done),
    .o_sync  (w_cdSync)
  );

  Synchronizer #(.WIDTH(DISPLAY_W)) u_syncDisplay (
    .clock   (clock),
    .reset   (reset),
    .i_async (bus.display_in),
    .o_sync  (w_dispSync)
  );

  assign w_lastHold = (r_holdCnt == '0);
  assign w_haveData = (w_count != '0);
  assign w_pop      = (r_state == PULSE) && w_lastHold && !w_empty;

  // input_data is loaded only on SETUP entry (or cleared on DONE entry), so it
  // can never move while Next is high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_holdCnt     <= '0;
      r_waitCnt     <= '0;
      r_data        <= '0;
      r_busy        <= 1'b0;
      r_next        <= 1'b0;
      r_done        <= 1'b0;
      r_result      <= '0;
      r_resultValid <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_resultValid <= 1'b0;
      r_timeout     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_busy    <= 1'b1;
            r_holdCnt <= HCW'(HOLD - 1);
            if (w_haveData) begin
              r_state <= SETUP;
              r_data  <= w_head;
            end else begin
              r_state <= DONE;
              r_data  <= '0;
              r_done  <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (w_lastHold) begin
            r_state   <= PULSE;
            r_next    <= 1'b1;
            r_holdCnt <= HCW'(HOLD - 1);
          end else begin
            r_holdCnt <= r_holdCnt - 1'b1;
          end
        end
        PULSE: begin
          if (w_lastHold) begin
            r_state   <= GAP;
            r_next    <= 1'b0;
            r_holdCnt <= HCW'(HOLD - 1);
          end else begin
            r_holdCnt <= r_holdCnt - 1'b1;
          end
        end
        // Nibbles pushed while streaming are picked up here, so they join this run.
        GAP: begin
          if (w_lastHold) begin
            r_holdCnt <= HCW'(HOLD - 1);
            if (w_haveData) begin
              r_state <= SETUP;
              r_data  <= w_head;
            end else begin
              r_state <= DONE;
              r_data  <= '0;
              r_done  <= 1'b1;
            end
          end else begin
            r_holdCnt <= r_holdCnt - 1'b1;
          end
        end
        DONE: begin
          if (w_lastHold) begin
            r_state   <= WAIT;
            r_done    <= 1'b0;
            r_waitCnt <= '0;
          end else begin
            r_holdCnt <= r_holdCnt - 1'b1;
          end
        end
        WAIT: begin
          if (w_cdSync) begin
            r_result      <= w_dispSync;
            r_resultValid <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= IDLE;
          end else if (r_waitCnt == TCW'(TIMEOUT - 1)) begin
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_waitCnt <= r_waitCnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.full         = w_full;
  assign bus.busy         = r_busy;
  assign bus.input_data   = r_data;
  assign bus.Next         = r_next;
  assign bus.Done         = r_done;
  assign bus.result       = r_result;
  assign bus.result_valid = r_resultValid;
  assign bus.timeout      = r_timeout;
endmodule

// File: tb/tb_tm_tape_loader.sv
// Directed bench for tm_tape_loader (DEPTH=16, HOLD=4, TIMEOUT=32).
// Outputs are sampled on the falling edge; inputs change there too.
module tb_tm_tape_loader;
  import tm_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   testsRun = 0;
  int   testsFailed = 0;

  bit         qNext[$];
  bit         qDone[$];
  bit         qBusy[$];
  logic [3:0] qData[$];
  int         pulseStart[$];
  int         pulseLen[$];
  logic [3:0] pulseData[$];
  int         doneLen;
  int         doneFirst;
  bit         stableOk;
  bit         doneDataZero;

  tm_tape_loader_if bus();

  tm_tape_loader #(.DEPTH(16), .HOLD(4), .TIMEOUT(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pushOne(input logic [3:0] v);
    @(negedge clock);
    bus.wr_en   = 1'b1;
    bus.wr_data = v;
    @(negedge clock);
    bus.wr_en   = 1'b0;
  endtask

  // Records one run from the first sample after start until Done has fallen.
  task automatic captureRun(input int maxCyc, input int restartAt, input bit latePush,
                            input logic [3:0] lateVal, output bit timedOut);
    bit sawDone = 1'b0;
    bit pushed  = 1'b0;
    int n = 0;
    qNext.delete(); qDone.delete(); qBusy.delete(); qData.delete();
    timedOut = 1'b1;
    while (n < maxCyc) begin
      @(negedge clock);
      bus.start = (n == restartAt);
      bus.wr_en = 1'b0;
      qNext.push_back(bus.Next);
      qDone.push_back(bus.Done);
      qBusy.push_back(bus.busy);
      qData.push_back(bus.input_data);
      if (latePush && !pushed && bus.Next) begin
        bus.wr_en   = 1'b1;
        bus.wr_data = lateVal;
        pushed      = 1'b1;
      end
      n++;
      if (bus.Done) sawDone = 1'b1;
      else if (sawDone) begin
        timedOut = 1'b0;
        break;
      end
    end
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
  endtask

  task automatic analyzeRun();
    pulseStart.delete(); pulseLen.delete(); pulseData.delete();
    doneLen = 0; doneFirst = -1; stableOk = 1'b1; doneDataZero = 1'b1;
    for (int k = 0; k < qNext.size(); k++) begin
      if (qNext[k]) begin
        if (k == 0) begin
          pulseStart.push_back(k); pulseLen.push_back(0); pulseData.push_back(qData[k]);
        end else if (!qNext[k-1]) begin
          pulseStart.push_back(k); pulseLen.push_back(0); pulseData.push_back(qData[k]);
        end
        pulseLen[pulseLen.size()-1] = pulseLen[pulseLen.size()-1] + 1;
      end
      if (qDone[k]) begin
        doneLen++;
        if (doneFirst < 0) doneFirst = k;
        if (qData[k] !== 4'h0) doneDataZero = 1'b0;
      end
    end
    for (int p = 0; p < pulseStart.size(); p++)
      for (int k = pulseStart[p] - 4; k <= pulseStart[p] + pulseLen[p] + 3; k++)
        if (k >= 0 && k < qData.size())
          if (qData[k] !== pulseData[p]) stableOk = 1'b0;
  endtask

  task automatic respondCompute(input logic [10:0] disp, output int firstAt, output int nValid);
    firstAt = -1;
    nValid  = 0;
    bus.compute_done = 1'b1;
    bus.display_in   = disp;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (bus.result_valid) begin
        nValid++;
        if (firstAt < 0) firstAt = k;
      end
    end
    bus.compute_done = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.start = 1'b0;
    bus.compute_done = 1'b0; bus.display_in = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    testsRun++;
    if ({bus.busy, bus.Next, bus.Done, bus.result_valid, bus.timeout, bus.full} !== 6'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_flags: got %b, want 000000",
               {bus.busy, bus.Next, bus.Done, bus.result_valid, bus.timeout, bus.full});
    end
    testsRun++;
    if (bus.input_data !== 4'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_data: got %h, want 0", bus.input_data);
    end
    testsRun++;
    if (bus.result !== 11'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_result: got %h, want 000", bus.result);
    end
  endtask

  task automatic test_stream();
    logic [3:0] expData [3];
    bit to;
    int firstAt, nValid, gotLen, gotStart;
    logic [3:0] gotData;
    expData[0] = 4'h3; expData[1] = 4'hA; expData[2] = 4'h5;
    pushOne(4'h3); pushOne(4'hA); pushOne(4'h5);
    @(negedge clock); bus.start = 1'b1;
    captureRun(100, 6, 1'b0, 4'h0, to);
    testsRun++;
    if (to) begin testsFailed++; $display("[TB] FAIL stream_bound: got no Done fall, want one"); end
    analyzeRun();
    testsRun++;
    if (qBusy[0] !== 1'b1) begin testsFailed++; $display("[TB] FAIL stream_busy_rise: got %b, want 1", qBusy[0]); end
    testsRun++;
    if (pulseStart.size() != 3) begin
      testsFailed++; $display("[TB] FAIL stream_pulses: got %0d, want 3", pulseStart.size());
    end
    for (int p = 0; p < 3; p++) begin
      gotLen   = (p < pulseLen.size()) ? pulseLen[p] : -1;
      gotStart = (p < pulseStart.size()) ? pulseStart[p] : -1;
      gotData  = (p < pulseData.size()) ? pulseData[p] : 4'hx;
      testsRun++;
      if (gotLen != 4 || gotStart != 4 + 12*p || gotData !== expData[p]) begin
        testsFailed++;
        $display("[TB] FAIL stream_pulse%0d: got len=%0d start=%0d data=%h, want len=4 start=%0d data=%h",
                 p, gotLen, gotStart, gotData, 4 + 12*p, expData[p]);
      end
    end
    testsRun++;
    if (!stableOk) begin testsFailed++; $display("[TB] FAIL stream_stable: got 0, want 1"); end
    testsRun++;
    if (doneLen != 4 || doneFirst != 36 || !doneDataZero) begin
      testsFailed++;
      $display("[TB] FAIL stream_done: got len=%0d first=%0d zero=%0b, want len=4 first=36 zero=1",
               doneLen, doneFirst, doneDataZero);
    end
    respondCompute(11'h155, firstAt, nValid);
    testsRun++;
    if (bus.result !== 11'h155 || nValid != 1) begin
      testsFailed++;
      $display("[TB] FAIL stream_result: got %h/%0d pulses, want 155/1", bus.result, nValid);
    end
  endtask

  task automatic test_empty_done();
    bit to;
    int firstAt, nValid;
    @(negedge clock); bus.start = 1'b1;
    captureRun(40, -1, 1'b0, 4'h0, to);
    testsRun++;
    if (to) begin testsFailed++; $display("[TB] FAIL empty_bound: got no Done fall, want one"); end
    analyzeRun();
    testsRun++;
    if (pulseStart.size() != 0 || doneLen != 4 || doneFirst != 0) begin
      testsFailed++;
      $display("[TB] FAIL empty_done: got pulses=%0d len=%0d first=%0d, want 0/4/0",
               pulseStart.size(), doneLen, doneFirst);
    end
    respondCompute(11'h2A5, firstAt, nValid);
    testsRun++;
    if (!(firstAt >= 2 && firstAt <= 3) || nValid != 1) begin
      testsFailed++;
      $display("[TB] FAIL empty_valid: got latency=%0d pulses=%0d, want 2..3/1", firstAt, nValid);
    end
    testsRun++;
    if (bus.result !== 11'h2A5 || bus.busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL empty_result: got %h busy=%b, want 2a5 busy=0", bus.result, bus.busy);
    end
  endtask

  task automatic test_full();
    bit to;
    int firstAt, nValid, badOrder;
    for (int i = 0; i < 17; i++) begin
      @(negedge clock);
      if (i == 15) begin
        testsRun++;
        if (bus.full !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_at15: got %b, want 0", bus.full); end
      end
      if (i == 16) begin
        testsRun++;
        if (bus.full !== 1'b1) begin testsFailed++; $display("[TB] FAIL full_at16: got %b, want 1", bus.full); end
      end
      bus.wr_en   = 1'b1;
      bus.wr_data = (i < 16) ? 4'(i ^ 5) : 4'hC;
    end
    @(negedge clock); bus.wr_en = 1'b0;
    testsRun++;
    if (bus.full !== 1'b1) begin testsFailed++; $display("[TB] FAIL full_drop: got %b, want 1", bus.full); end
    bus.start = 1'b1;
    captureRun(400, -1, 1'b0, 4'h0, to);
    testsRun++;
    if (to) begin testsFailed++; $display("[TB] FAIL full_bound: got no Done fall, want one"); end
    analyzeRun();
    testsRun++;
    if (pulseStart.size() != 16) begin
      testsFailed++; $display("[TB] FAIL full_pulses: got %0d, want 16", pulseStart.size());
    end
    badOrder = 0;
    for (int k = 0; k < 16; k++)
      if (k >= pulseData.size() || pulseData[k] !== 4'(k ^ 5)) badOrder++;
    testsRun++;
    if (badOrder != 0) begin testsFailed++; $display("[TB] FAIL full_order: got %0d wrong nibbles, want 0", badOrder); end
    testsRun++;
    if (bus.full !== 1'b0 || doneLen != 4) begin
      testsFailed++; $display("[TB] FAIL full_drain: got full=%b done=%0d, want 0/4", bus.full, doneLen);
    end
    respondCompute(11'h7FF, firstAt, nValid);
    testsRun++;
    if (bus.result !== 11'h7FF) begin testsFailed++; $display("[TB] FAIL full_result: got %h, want 7ff", bus.result); end
  endtask

  task automatic test_timeout();
    bit to, sawValid, busyAtTo;
    int toAt, toCount;
    @(negedge clock); bus.start = 1'b1;
    captureRun(40, -1, 1'b0, 4'h0, to);
    testsRun++;
    if (to) begin testsFailed++; $display("[TB] FAIL timeout_bound: got no Done fall, want one"); end
    toAt = -1; toCount = 0; sawValid = 1'b0; busyAtTo = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (bus.result_valid) sawValid = 1'b1;
      if (bus.timeout) begin
        toCount++;
        if (toAt < 0) begin toAt = k; busyAtTo = bus.busy; end
      end
    end
    testsRun++;
    if (toAt != 32 || toCount != 1) begin
      testsFailed++; $display("[TB] FAIL timeout_at: got at=%0d count=%0d, want 32/1", toAt, toCount);
    end
    testsRun++;
    if (busyAtTo !== 1'b0 || sawValid) begin
      testsFailed++; $display("[TB] FAIL timeout_busy: got busy=%b valid=%b, want 0/0", busyAtTo, sawValid);
    end
    testsRun++;
    if (bus.result !== 11'h7FF) begin testsFailed++; $display("[TB] FAIL timeout_result: got %h, want 7ff", bus.result); end
  endtask

  task automatic test_reset_midstream();
    bit to, reached, prev;
    int rises;
    pushOne(4'h1); pushOne(4'h2); pushOne(4'h3);
    @(negedge clock); bus.start = 1'b1;
    rises = 0; prev = 1'b0; reached = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      bus.start = 1'b0;
      if (bus.Next && !prev) rises++;
      prev = bus.Next;
      if (rises == 2) begin reached = 1'b1; break; end
    end
    testsRun++;
    if (!reached) begin testsFailed++; $display("[TB] FAIL midreset_reach: got %0d pulses, want 2", rises); end
    reset = 1'b1;
    #1;
    testsRun++;
    if ({bus.Next, bus.Done, bus.busy, bus.full} !== 4'b0 || bus.input_data !== 4'h0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_out: got flags=%b data=%h, want 0000/0",
               {bus.Next, bus.Done, bus.busy, bus.full}, bus.input_data);
    end
    testsRun++;
    if (bus.result !== 11'h0) begin testsFailed++; $display("[TB] FAIL midreset_result: got %h, want 000", bus.result); end
    @(negedge clock); reset = 1'b0;
    @(negedge clock); bus.start = 1'b1;
    captureRun(40, -1, 1'b0, 4'h0, to);
    analyzeRun();
    testsRun++;
    if (to || pulseStart.size() != 0 || doneFirst != 0 || doneLen != 4) begin
      testsFailed++;
      $display("[TB] FAIL midreset_empty: got to=%b pulses=%0d first=%0d len=%0d, want 0/0/0/4",
               to, pulseStart.size(), doneFirst, doneLen);
    end
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      if (!bus.busy) break;
    end
    testsRun++;
    if (bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_idle: got busy=%b, want 0", bus.busy); end
  endtask

  task automatic test_late_push();
    bit to;
    int firstAt, nValid;
    pushOne(4'h7);
    @(negedge clock); bus.start = 1'b1;
    captureRun(100, -1, 1'b1, 4'h9, to);
    testsRun++;
    if (to) begin testsFailed++; $display("[TB] FAIL late_bound: got no Done fall, want one"); end
    analyzeRun();
    testsRun++;
    if (pulseStart.size() != 2) begin
      testsFailed++; $display("[TB] FAIL late_pulses: got %0d, want 2", pulseStart.size());
    end else if (pulseData[0] !== 4'h7 || pulseData[1] !== 4'h9) begin
      testsFailed++; $display("[TB] FAIL late_data: got %h,%h, want 7,9", pulseData[0], pulseData[1]);
    end
    testsRun++;
    if (doneFirst != 24 || doneLen != 4) begin
      testsFailed++; $display("[TB] FAIL late_done: got first=%0d len=%0d, want 24/4", doneFirst, doneLen);
    end
    respondCompute(11'h0F0, firstAt, nValid);
    testsRun++;
    if (bus.result !== 11'h0F0) begin testsFailed++; $display("[TB] FAIL late_result: got %h, want 0f0", bus.result); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_empty_done();
    test_full();
    test_timeout();
    test_reset_midstream();
    test_late_push();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule

// File: doc/tm_tape_loader.md
TM_TAPE_LOADER -- requirements
Module: tm_tape_loader

Interface
REQ-001 Parameter DEPTH, 16, nibble FIFO entries; power of two, at least 2.
REQ-002 Parameter HOLD, 4, cycles each level on Next/Done is held; at least 3, so a 2-flop receiver synchronizer samples it.
REQ-003 Parameter TIMEOUT, 4096, maximum WAIT cycles before abort.
REQ-004 clock  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 wr_en  input  1  push wr_data into FIFO when not full.
REQ-007 wr_data  input  4  tape nibble.
REQ-008 start  input  1  one-cycle request to stream FIFO contents and run.
REQ-009 full  output  1  FIFO holds DEPTH entries.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 input_data  output  4  nibble presented to the machine.
REQ-012 Next  output  1  strobe: current nibble valid.
REQ-013 Done  output  1  strobe: tape complete, begin compute.
REQ-014 compute_done  input  1  asynchronous completion flag from the machine.
REQ-015 display_in  input  11  asynchronous display bus from the machine.
REQ-016 result  output  11  captured display value.
REQ-017 result_valid  output  1  one-cycle pulse, result updated.
REQ-018 timeout  output  1  one-cycle pulse, WAIT aborted.

Function
REQ-019 States: IDLE, SETUP, PULSE, GAP, DONE, WAIT; one HOLD-cycle down-counter times SETUP, PULSE, GAP and DONE.
REQ-020 IDLE with start=1: FIFO non-empty -> SETUP; FIFO empty -> DONE; busy rises the following cycle.
REQ-021 SETUP: input_data = FIFO head, Next=0, HOLD cycles, then PULSE.
REQ-022 PULSE: input_data held, Next=1 for exactly HOLD cycles; FIFO pops on the last PULSE cycle; then GAP.
REQ-023 GAP: Next=0, input_data held, HOLD cycles; then SETUP if FIFO non-empty, else DONE.
REQ-024 DONE: Done=1 for exactly HOLD cycles, input_data=0; then WAIT.
REQ-025 input_data changes only on SETUP entry, so it is never changed while Next=1.
REQ-026 WAIT: on the first cycle synchronized compute_done=1, result <= synchronized display_in, result_valid=1 that cycle, -> IDLE.
REQ-027 WAIT: after TIMEOUT cycles without compute_done, timeout=1 for one cycle, result unchanged, -> IDLE.
REQ-028 compute_done and display_in pass through 2-flop synchronizers before use; response latency from a compute_done edge is 2-3 cycles.
REQ-029 FIFO: push when wr_en=1 and not full, in any state; push when full is dropped, no error; a push and pop in the same cycle both occur, count unchanged.
REQ-030 Pointers wrap modulo DEPTH; full and empty are derived from an explicit count of width log2(DEPTH)+1.
REQ-031 A nibble pushed during streaming, before the GAP exit decision, is sent in the same run.
REQ-032 start is ignored when busy=1.

Reset
REQ-033 reset=1 forces IDLE immediately, empties the FIFO, and drives all outputs 0 (result=0), mid-operation included.
REQ-034 Synchronizer flops and counters reset to 0.

Structure
REQ-035 Shared package tm_pkg holds the state enum, NIBBLE_W=4, and DISPLAY_W=11.
REQ-036 One sub-module, tm_nibble_fifo (DEPTH x 4, push/pop/full/empty/count); the synchronizer reuses the codebase's existing Synchronizer.

Verification
REQ-037 HOLD=4. Push 3,A,5, then start -> three Next pulses, each 4 cycles high, input_data 3,A,5 stable from 4 cycles before through 4 cycles after each pulse, then Done high 4 cycles.
REQ-038 Empty FIFO, start -> no Next; Done 4 cycles; compute_done=1 with display_in=0x2A5 -> result=0x2A5, result_valid pulses once within 3 cycles.
REQ-039 Push 17 nibbles with DEPTH=16 -> full=1 after the 16th; the 17th is dropped; 16 Next pulses are sent.
REQ-040 TIMEOUT=32, compute_done held 0 -> timeout pulses exactly 32 cycles after WAIT entry, then busy=0; result unchanged.
REQ-041 Assert reset during the second PULSE -> Next, Done, busy and input_data are 0 in the same cycle; FIFO empty; a later start goes directly to DONE.
REQ-042 Push 9 during PULSE of the last queued nibble -> 9 is sent before Done.
